// File: rtl/output_serializer_pkg.sv
// Shared types and constants for the output serializer.
// Holds the FSM state enum, default word geometry and a width helper.
package output_serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int VECTOR_SIZE_DFLT  = 6;
    localparam int OUTPUT_WIDTH_DFLT = 8;
    localparam int WORD_WIDTH        = VECTOR_SIZE_DFLT * OUTPUT_WIDTH_DFLT;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/output_fifo.sv
// Small word FIFO with registered storage and a combinational head read.
// Ports: clock, reset (sync, active-low), push/wdata, pop/rdata,
// full, empty, count. Push is refused when full at the start of the
// cycle even if a pop happens in the same cycle.
module output_fifo
    import output_serializer_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = idx_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage needs no reset: it is only read while count is non-zero.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/output_serializer.sv
// Captures CPU result words into a FIFO and streams them lane by lane,
// lane 0 first, over a valid/ready byte interface.
// Ports: clock, reset (sync, active-low), out/outFlag word input,
// byteData/byteValid/byteReady stream, fifoFull, overflow (sticky), busy.
module output_serializer
    import output_serializer_pkg::*;
#(
    parameter int VECTOR_SIZE  = VECTOR_SIZE_DFLT,
    parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DFLT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0] out,
    input  logic                                outFlag,
    output logic [OUTPUT_WIDTH-1:0]             byteData,
    output logic                                byteValid,
    input  logic                                byteReady,
    output logic                                fifoFull,
    output logic                                overflow,
    output logic                                busy
);

    localparam int WW = VECTOR_SIZE * OUTPUT_WIDTH;
    localparam int IW = idx_width(VECTOR_SIZE);
    localparam logic [IW-1:0] LAST = IW'(VECTOR_SIZE - 1);

    state_t                    state_q, state_d;
    logic [WW-1:0]             sh_q, sh_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      ovf_q, ovf_d;
    logic                      pop;
    logic [WW-1:0]             head;
    logic                      full;
    logic                      empty;
    logic [$clog2(FIFO_DEPTH):0] count;

    output_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (outFlag),
        .wdata (out),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign byteValid = (state_q == SEND);
    assign byteData  = byteValid ? sh_q[OUTPUT_WIDTH-1:0] : '0;
    assign fifoFull  = full;
    assign overflow  = ovf_q;
    assign busy      = (count != '0) || (state_q == SEND);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        ovf_d   = ovf_q || (outFlag && full);
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = head;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (byteReady) begin
                    if (idx_q == LAST) begin
                        // Chain straight into the next word when one is
                        // queued so back-to-back words have no bubble.
                        if (!empty) begin
                            pop   = 1'b1;
                            sh_d  = head;
                            idx_d = '0;
                        end else begin
                            sh_d    = '0;
                            idx_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        sh_d  = sh_q >> OUTPUT_WIDTH;
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_output_serializer.sv
// Scoreboard bench for output_serializer: stimulus queues expected bytes,
// a negedge monitor pops and compares every accepted byte.
module tb_output_serializer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [47:0] out = '0;
    logic        outFlag = 1'b0;
    logic [7:0]  byteData;
    logic        byteValid;
    logic        byteReady = 1'b0;
    logic        fifoFull;
    logic        overflow;
    logic        busy;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    int          acc_cyc[$];

    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        prst = 1'b0;
    logic [7:0]  pd = '0;

    output_serializer dut (
        .clock     (clock),
        .reset     (reset),
        .out       (out),
        .outFlag   (outFlag),
        .byteData  (byteData),
        .byteValid (byteValid),
        .byteReady (byteReady),
        .fifoFull  (fifoFull),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(string nm, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [47:0] mk(logic [7:0] b);
        logic [47:0] r;
        for (int j = 0; j < 6; j++) r[8*j +: 8] = b + 8'(j);
        return r;
    endfunction

    task automatic expect_word(logic [47:0] w);
        for (int j = 0; j < 6; j++) exp_q.push_back(w[8*j +: 8]);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(string nm);
        byteReady = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!busy) break;
        end
        check({nm, "_idle"}, 64'(busy), 64'(0));
        check({nm, "_all_bytes"}, 64'(exp_q.size()), 64'(0));
    endtask

    // Monitor: byte scoreboard, hold stability, zero data when idle.
    always @(negedge clock) begin
        cyc++;
        if (cyc > 1) begin
            if (!byteValid) check("idle_data_zero", 64'(byteData), 64'(0));
            if (pv && !pr && prst) begin
                check("hold_valid", 64'(byteValid), 64'(1));
                check("hold_data", 64'(byteData), 64'(pd));
            end
            if (reset && byteValid && byteReady) begin
                acc_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %0h expected none",
                             byteData);
                end else begin
                    check("byte", 64'(byteData), 64'(exp_q.pop_front()));
                end
            end
        end
        pv   = byteValid;
        pr   = byteReady;
        prst = reset;
        pd   = byteData;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        pat = 4'b1001;

        // 1: reset then quiet
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_valid", 64'(byteValid), 64'(0));
        check("rst_data", 64'(byteData), 64'(0));
        check("rst_full", 64'(fifoFull), 64'(0));
        check("rst_ovf", 64'(overflow), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        step();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("t1_valid", 64'(byteValid), 64'(0));
            check("t1_busy", 64'(busy), 64'(0));
            check("t1_ovf", 64'(overflow), 64'(0));
        end
        step();

        // 2: single word latency and order
        byteReady = 1'b1;
        out = 48'h060504030201;
        outFlag = 1'b1;
        expect_word(out);
        @(negedge clock);
        check("t2_lat_n", 64'(byteValid), 64'(0));
        step();
        outFlag = 1'b0;
        @(negedge clock);
        check("t2_lat_n1", 64'(byteValid), 64'(0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("t2_stream", 64'(byteValid), 64'(1));
        end
        @(negedge clock);
        check("t2_end_valid", 64'(byteValid), 64'(0));
        check("t2_end_busy", 64'(busy), 64'(0));
        check("t2_all_bytes", 64'(exp_q.size()), 64'(0));
        step();

        // 3: fill (shift reg + 4 FIFO words), then a dropped word
        byteReady = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            out = mk(8'(8'h11 * k));
            outFlag = 1'b1;
            expect_word(out);
            step();
        end
        @(negedge clock);
        check("t3_full", 64'(fifoFull), 64'(1));
        check("t3_no_ovf", 64'(overflow), 64'(0));
        step();
        out = mk(8'h66);
        outFlag = 1'b1;
        step();
        outFlag = 1'b0;
        @(negedge clock);
        check("t3_ovf", 64'(overflow), 64'(1));
        check("t3_still_full", 64'(fifoFull), 64'(1));
        step();
        drain("t3");
        check("t3_ovf_sticky", 64'(overflow), 64'(1));
        step();

        // 4: backpressure pattern 1,0,0,1
        out = 48'hF6F5F4F3F2F1;
        outFlag = 1'b1;
        expect_word(out);
        step();
        outFlag = 1'b0;
        for (int i = 0; i < 40; i++) begin
            byteReady = pat[i % 4];
            step();
        end
        drain("t4");
        step();

        // 5: back-to-back words, then drop during a pop at full
        reset = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clock);
        check("t5_ovf_clr", 64'(overflow), 64'(0));
        step();
        byteReady = 1'b1;
        acc_cyc.delete();
        out = mk(8'h70);
        outFlag = 1'b1;
        expect_word(out);
        step();
        out = mk(8'h80);
        expect_word(out);
        step();
        outFlag = 1'b0;
        drain("t5a");
        check("t5_count", 64'(acc_cyc.size()), 64'(12));
        if (acc_cyc.size() == 12)
            check("t5_no_bubble", 64'(acc_cyc[11] - acc_cyc[0]), 64'(11));
        step();
        byteReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            out = mk(8'(8'hA0 + 16 * k));
            outFlag = 1'b1;
            expect_word(out);
            step();
        end
        outFlag = 1'b0;
        step();
        @(negedge clock);
        check("t5_full", 64'(fifoFull), 64'(1));
        step();
        byteReady = 1'b1;
        repeat (5) step();
        out = mk(8'h30);
        outFlag = 1'b1;
        @(negedge clock);
        check("t5_pop_now", 64'(byteValid && byteReady), 64'(1));
        check("t5_full_at_pop", 64'(fifoFull), 64'(1));
        check("t5_ovf_before", 64'(overflow), 64'(0));
        step();
        outFlag = 1'b0;
        @(negedge clock);
        check("t5_ovf_drop", 64'(overflow), 64'(1));
        check("t5_not_full", 64'(fifoFull), 64'(0));
        step();
        drain("t5b");
        step();

        // 6: reset mid-word discards everything
        byteReady = 1'b1;
        out = 48'hAABBCCDDEEFF;
        outFlag = 1'b1;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hEE);
        exp_q.push_back(8'hDD);
        step();
        out = mk(8'h90);
        step();
        outFlag = 1'b0;
        step();
        step();
        step();
        byteReady = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clock);
        check("t6_valid", 64'(byteValid), 64'(0));
        check("t6_busy", 64'(busy), 64'(0));
        check("t6_full", 64'(fifoFull), 64'(0));
        check("t6_ovf", 64'(overflow), 64'(0));
        check("t6_bytes", 64'(exp_q.size()), 64'(0));
        step();
        byteReady = 1'b1;
        out = 48'h0C0B0A090807;
        outFlag = 1'b1;
        expect_word(out);
        step();
        outFlag = 1'b0;
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
